// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: request/lock/data inputs and grant/register outputs of the shared-register arbiter
interface reg_write_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] din;
    logic [N-1:0]   gnt;
    logic [2:0]     owner;
    logic [W-1:0]   q;
    logic           valid;
    modport master (output req, lock, din, input gnt, owner, q, valid);
    modport slave  (input req, lock, din, output gnt, owner, q, valid);
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter granting N requesters write access to one shared register
module reg_write_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int LOCK_MAX = 8
) (
    input logic clk,
    input logic reset,
    reg_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(N);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] own;
    logic [7:0]    cnt;
    logic          found;
    assign own = bus.owner[PW-1:0];
    // first requester at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && bus.req[PW'((int'(ptr) + k) % N)]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + k) % N);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            bus.gnt   <= '0;
            bus.owner <= '0;
            bus.q     <= '0;
            bus.valid <= 1'b0;
        end else if (state == IDLE) begin
            if (found) begin
                state     <= GRANT;
                ptr       <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
                cnt       <= 8'd1;
                bus.gnt   <= N'(1) << win;
                bus.owner <= 3'(win);
                bus.q     <= bus.din[int'(win)*W +: W];
                bus.valid <= 1'b1;
            end else begin
                bus.gnt   <= '0;
                bus.valid <= 1'b0;
            end
        end else if (bus.req[own] && bus.lock[own] && cnt < 8'(LOCK_MAX)) begin
            cnt       <= cnt + 8'd1;
            bus.q     <= bus.din[int'(own)*W +: W];
            bus.valid <= 1'b1;
        end else begin
            state     <= IDLE;
            cnt       <= '0;
            bus.gnt   <= '0;
            bus.valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed steps with a per-edge scoreboard of expected gnt/owner/q/valid
module tb_reg_write_arbiter;
    typedef struct {
        logic [3:0] gnt;
        logic [2:0] owner;
        logic [7:0] q;
        logic       valid;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total = 0;
    exp_t sb[$];
    reg_write_arbiter_if #(.N(4), .W(8)) bus ();
    reg_write_arbiter #(.N(4), .W(8), .LOCK_MAX(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic push(input logic [3:0] g, input logic [2:0] o, input logic [7:0] qv, input logic v);
        exp_t e;
        e.gnt = g; e.owner = o; e.q = qv; e.valid = v;
        sb.push_back(e);
    endtask
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("gnt", 32'(bus.gnt), 32'(e.gnt));
            chk("q", 32'(bus.q), 32'(e.q));
            chk("valid", 32'(bus.valid), 32'(e.valid));
            if (e.valid) chk("owner", 32'(bus.owner), 32'(e.owner));
        end
    endtask
    task automatic setd(input int i, input logic [7:0] v);
        bus.din[i*8 +: 8] = v;
    endtask
    initial begin
        bus.req = '0;
        bus.lock = '0;
        bus.din = '0;
        push(4'b0000, 3'd0, 8'h00, 1'b0); tick();
        chk("reset_owner", 32'(bus.owner), 32'd0);
        reset = 1'b0;
        // two requesters, unlocked, with the idle bubble between them
        setd(0, 8'h11); setd(2, 8'h33);
        bus.req = 4'b0101;
        push(4'b0001, 3'd0, 8'h11, 1'b1); tick();
        bus.req = 4'b0100;
        push(4'b0000, 3'd0, 8'h11, 1'b0); tick();
        push(4'b0100, 3'd2, 8'h33, 1'b1); tick();
        bus.req = 4'b0000;
        push(4'b0000, 3'd0, 8'h33, 1'b0); tick();
        push(4'b0000, 3'd0, 8'h33, 1'b0); tick();
        // fairness with every requester pending, including pointer wrap
        reset = 1'b1;
        push(4'b0000, 3'd0, 8'h00, 1'b0); tick();
        reset = 1'b0;
        bus.din = 32'h44332211;
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            push(4'(1 << i), 3'(i), 8'(8'h11 * (i + 1)), 1'b1); tick();
            push(4'b0000, 3'd0, 8'(8'h11 * (i + 1)), 1'b0); tick();
        end
        push(4'b0001, 3'd0, 8'h11, 1'b1); tick();
        bus.req = 4'b0000;
        push(4'b0000, 3'd0, 8'h11, 1'b0); tick();
        // locked ownership capped at LOCK_MAX while a non-owner toggles req/lock
        bus.req = 4'b0010;
        bus.lock = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            setd(1, 8'(8'h40 + i));
            bus.req[0] = i[0];
            bus.lock[0] = 1'b1;
            push(4'b0010, 3'd1, 8'(8'h40 + i), 1'b1); tick();
        end
        bus.req = 4'b0010;
        bus.lock = 4'b0010;
        setd(1, 8'h48);
        push(4'b0000, 3'd0, 8'h47, 1'b0); tick();
        push(4'b0010, 3'd1, 8'h48, 1'b1); tick();
        bus.req = 4'b0000;
        bus.lock = 4'b0000;
        push(4'b0000, 3'd0, 8'h48, 1'b0); tick();
        // reset in the middle of a locked grant
        setd(3, 8'h55);
        bus.req = 4'b1000;
        bus.lock = 4'b1000;
        push(4'b1000, 3'd3, 8'h55, 1'b1); tick();
        push(4'b1000, 3'd3, 8'h55, 1'b1); tick();
        reset = 1'b1;
        bus.req = 4'b1101;
        push(4'b0000, 3'd0, 8'h00, 1'b0); tick();
        chk("reset_owner_mid_grant", 32'(bus.owner), 32'd0);
        reset = 1'b0;
        push(4'b0001, 3'd0, 8'h11, 1'b1); tick();
        bus.req = 4'b0000;
        bus.lock = 4'b0000;
        push(4'b0000, 3'd0, 8'h11, 1'b0); tick();
        // lock without req never creates ownership
        bus.lock = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            push(4'b0000, 3'd0, 8'h11, 1'b0); tick();
        end
        bus.lock = 4'b0000;
        // single grant per request; req still high on the edge after gnt
        setd(2, 8'h77);
        bus.req = 4'b0100;
        push(4'b0100, 3'd2, 8'h77, 1'b1); tick();
        setd(2, 8'h78);
        push(4'b0000, 3'd0, 8'h77, 1'b0); tick();
        bus.req = 4'b0000;
        push(4'b0000, 3'd0, 8'h77, 1'b0); tick();
        push(4'b0000, 3'd0, 8'h77, 1'b0); tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
